// File: rtl/timer_pkg.sv
// Shared definitions for the timer: register map, CTRL field layout,
// mode encodings and FSM state encoding.
package timer_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 2;

    localparam logic [ADDR_W-1:0] REG_CTRL   = 2'd0;
    localparam logic [ADDR_W-1:0] REG_PRESET = 2'd1;
    localparam logic [ADDR_W-1:0] REG_COUNT  = 2'd2;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_MODE_LSB = 1;
    localparam int unsigned CTRL_IM       = 3;

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'd0,
        MODE_RELOAD  = 2'd1,
        MODE_RSVD2   = 2'd2,
        MODE_RSVD3   = 2'd3
    } mode_e;

    typedef struct packed {
        logic  im;
        mode_e mode;
        logic  en;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_CNT  = 2'b10,
        ST_INT  = 2'b11
    } state_e;

endpackage

// File: rtl/timer_if.sv
// CPU-side register bus of the timer: decoded word select, write strobe,
// write/read data and the interrupt request.
interface timer_if;
    import timer_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic              We;
    logic [DATA_W-1:0] WD;
    logic [DATA_W-1:0] RD;
    logic              IRQ;

    modport master (output addr, output We, output WD, input RD, input IRQ);
    modport slave  (input addr, input We, input WD, output RD, output IRQ);

endinterface

// File: rtl/timer.sv
// Programmable down-counter timer with one-shot / auto-reload modes and a
// maskable interrupt; CPU writes take priority over the FSM.
module timer
    import timer_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    timer_if.slave bus
);

    state_e            state_q, state_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [DATA_W-1:0] preset_q, preset_d;
    logic [DATA_W-1:0] count_q, count_d;
    logic              irq_flag_q, irq_flag_d;

    logic wr_ctrl_c;
    logic wr_preset_c;

    assign wr_ctrl_c   = bus.We && (bus.addr == REG_CTRL);
    assign wr_preset_c = bus.We && (bus.addr == REG_PRESET);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    // FSM update first, then CPU writes override whatever the FSM decided.
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q.en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q.en) begin
                    state_d = ST_IDLE;
                end else if (count_q > DATA_W'(1)) begin
                    count_d = count_q - DATA_W'(1);
                end else begin
                    count_d    = '0;
                    state_d    = ST_INT;
                    irq_flag_d = 1'b1;
                end
            end
            ST_INT: begin
                if (ctrl_q.mode == MODE_RELOAD) begin
                    state_d    = ST_LOAD;
                    irq_flag_d = 1'b0;
                end else begin
                    ctrl_d.en = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr_preset_c) begin
            preset_d   = bus.WD;
            irq_flag_d = 1'b0;
        end

        // Clearing Enable parks the FSM in IDLE with COUNT frozen.
        if (wr_ctrl_c) begin
            ctrl_d.en   = bus.WD[CTRL_EN];
            ctrl_d.mode = mode_e'(bus.WD[CTRL_MODE_LSB +: 2]);
            ctrl_d.im   = bus.WD[CTRL_IM];
            irq_flag_d  = 1'b0;
            if (!bus.WD[CTRL_EN]) begin
                state_d = ST_IDLE;
                count_d = count_q;
            end
        end
    end

    always_comb begin
        bus.RD = '0;
        case (bus.addr)
            REG_CTRL: begin
                bus.RD[CTRL_EN]              = ctrl_q.en;
                bus.RD[CTRL_MODE_LSB +: 2]   = ctrl_q.mode;
                bus.RD[CTRL_IM]              = ctrl_q.im;
            end
            REG_PRESET: bus.RD = preset_q;
            REG_COUNT:  bus.RD = count_q;
            default:    bus.RD = '0;
        endcase
    end

    assign bus.IRQ = ctrl_q.im & irq_flag_q;

endmodule

// File: tb/tb_timer.sv
// Directed bench for the timer: a cycle-by-cycle vector table for one-shot
// and auto-reload runs, plus hand sequences for disable, zero preset and reset.
module tb_timer;
    import timer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    timer_if bus();

    timer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [1:0]  raddr;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    localparam int unsigned NVEC = 25;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic we, input logic [1:0] a, input logic [31:0] d,
                                input logic [1:0] ra, input logic [31:0] e, input logic irq);
        vec_t v;
        v.we = we; v.addr = a; v.wd = d; v.raddr = ra; v.exp_rd = e; v.exp_irq = irq;
        return v;
    endfunction

    // Drive one bus cycle across the next rising edge, then release the strobe.
    task automatic step(input logic we, input logic [1:0] a, input logic [31:0] d);
        bus.We   = we;
        bus.addr = a;
        bus.WD   = d;
        @(posedge clk);
        #1;
        bus.We = 1'b0;
    endtask

    task automatic chk_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        n_chk++;
        if (bus.RD !== exp) begin
            n_fail++;
            $display("FAIL %s: RD[addr %0d] = 0x%0h, expected 0x%0h", name, a, bus.RD, exp);
        end
    endtask

    task automatic chk_irq(input string name, input logic exp);
        #1;
        n_chk++;
        if (bus.IRQ !== exp) begin
            n_fail++;
            $display("FAIL %s: IRQ = %b, expected %b", name, bus.IRQ, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // One-shot, PRESET=5, CTRL=0x9 (Enable+IM): IRQ at E7, Enable clears at E8.
        vecs[0]  = mk(1, REG_PRESET, 32'd5,   REG_PRESET, 32'd5, 0);
        vecs[1]  = mk(1, REG_CTRL,   32'h9,   REG_CTRL,   32'h9, 0); // E0
        vecs[2]  = mk(0, REG_COUNT,  32'd0,   REG_COUNT,  32'd0, 0); // E1 LOAD
        vecs[3]  = mk(0, REG_COUNT,  32'd0,   REG_COUNT,  32'd5, 0); // E2
        vecs[4]  = mk(0, REG_COUNT,  32'd0,   REG_COUNT,  32'd4, 0);
        vecs[5]  = mk(0, REG_COUNT,  32'd0,   REG_COUNT,  32'd3, 0);
        vecs[6]  = mk(0, REG_COUNT,  32'd0,   REG_COUNT,  32'd2, 0);
        vecs[7]  = mk(0, REG_COUNT,  32'd0,   REG_COUNT,  32'd1, 0); // E6
        vecs[8]  = mk(0, REG_COUNT,  32'd0,   REG_COUNT,  32'd0, 1); // E7 INT
        vecs[9]  = mk(0, REG_CTRL,   32'd0,   REG_CTRL,   32'h8, 1); // E8 Enable cleared
        vecs[10] = mk(0, REG_CTRL,   32'd0,   REG_CTRL,   32'h8, 1); // IRQ held
        vecs[11] = mk(1, REG_CTRL,   32'h8,   REG_CTRL,   32'h8, 0); // CTRL write clears flag
        // Auto-reload, PRESET=3, CTRL=0xB: IRQ pulse every 5 cycles.
        vecs[12] = mk(1, REG_PRESET, 32'd3,   REG_PRESET, 32'd3, 0);
        vecs[13] = mk(1, REG_CTRL,   32'hB,   REG_COUNT,  32'd0, 0); // E0
        vecs[14] = mk(0, REG_COUNT,  32'd0,   REG_COUNT,  32'd0, 0); // E1 LOAD
        vecs[15] = mk(0, REG_COUNT,  32'd0,   REG_COUNT,  32'd3, 0);
        vecs[16] = mk(0, REG_COUNT,  32'd0,   REG_COUNT,  32'd2, 0);
        vecs[17] = mk(0, REG_COUNT,  32'd0,   REG_COUNT,  32'd1, 0);
        vecs[18] = mk(0, REG_COUNT,  32'd0,   REG_COUNT,  32'd0, 1); // E5 INT
        vecs[19] = mk(0, REG_COUNT,  32'd0,   REG_COUNT,  32'd0, 0); // E6 LOAD, pulse over
        vecs[20] = mk(0, REG_COUNT,  32'd0,   REG_COUNT,  32'd3, 0);
        vecs[21] = mk(0, REG_COUNT,  32'd0,   REG_COUNT,  32'd2, 0);
        vecs[22] = mk(0, REG_COUNT,  32'd0,   REG_COUNT,  32'd1, 0);
        vecs[23] = mk(0, REG_COUNT,  32'd0,   REG_COUNT,  32'd0, 1); // E10 INT
        vecs[24] = mk(0, REG_CTRL,   32'd0,   REG_CTRL,   32'hB, 0); // Enable kept

        reset    = 1'b0;
        bus.We   = 1'b0;
        bus.addr = REG_CTRL;
        bus.WD   = '0;
        #2;
        chk_reg("rst_ctrl", REG_CTRL, 32'd0);
        chk_reg("rst_preset", REG_PRESET, 32'd0);
        chk_reg("rst_count", REG_COUNT, 32'd0);
        chk_irq("rst_irq", 1'b0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < int'(NVEC); i++) begin
            step(vecs[i].we, vecs[i].addr, vecs[i].wd);
            chk_reg($sformatf("vec%0d_rd", i), vecs[i].raddr, vecs[i].exp_rd);
            chk_irq($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
        end

        // Stop auto-reload, then zero preset with IM=1: IRQ at E3, not E2.
        step(1, REG_CTRL, 32'h0);
        step(1, REG_PRESET, 32'd0);
        step(1, REG_CTRL, 32'h9);
        step(0, REG_COUNT, 32'd0);
        step(0, REG_COUNT, 32'd0);
        chk_irq("zp_e2_irq", 1'b0);
        step(0, REG_COUNT, 32'd0);
        chk_irq("zp_e3_irq", 1'b1);
        step(0, REG_COUNT, 32'd0);
        chk_reg("zp_e4_ctrl", REG_CTRL, 32'h8);

        // Zero preset, masked: flag sets internally, IRQ never visible.
        step(1, REG_CTRL, 32'h1);
        chk_irq("zpm_e0_irq", 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step(0, REG_CTRL, 32'd0);
            chk_irq($sformatf("zpm_e%0d_irq", k), 1'b0);
        end
        chk_reg("zpm_e3_ctrl", REG_CTRL, 32'h1);
        step(0, REG_CTRL, 32'd0);
        chk_reg("zpm_e4_ctrl", REG_CTRL, 32'h0);
        step(1, REG_CTRL, 32'h8);
        chk_irq("zpm_im_irq", 1'b0);
        step(0, REG_CTRL, 32'd0);
        chk_irq("zpm_im_irq2", 1'b0);

        // Disable mid-count, with a PRESET write during CNT.
        step(1, REG_PRESET, 32'd10);
        step(1, REG_CTRL, 32'h1);
        step(0, REG_COUNT, 32'd0);
        step(0, REG_COUNT, 32'd0);
        chk_reg("dis_e2", REG_COUNT, 32'd10);
        step(0, REG_COUNT, 32'd0);
        step(0, REG_COUNT, 32'd0);
        step(1, REG_PRESET, 32'd20);
        chk_reg("dis_preset_no_effect", REG_COUNT, 32'd7);
        step(0, REG_COUNT, 32'd0);
        chk_reg("dis_e6", REG_COUNT, 32'd6);
        step(1, REG_CTRL, 32'h0);
        chk_reg("dis_frozen", REG_COUNT, 32'd6);
        step(0, REG_COUNT, 32'd0);
        step(0, REG_COUNT, 32'd0);
        chk_reg("dis_held", REG_COUNT, 32'd6);
        chk_irq("dis_irq", 1'b0);
        step(1, REG_CTRL, 32'h1);
        chk_reg("reen_e0", REG_COUNT, 32'd6);
        step(0, REG_COUNT, 32'd0);
        chk_reg("reen_load", REG_COUNT, 32'd6);
        step(0, REG_COUNT, 32'd0);
        chk_reg("reen_new_preset", REG_COUNT, 32'd20);
        step(1, REG_CTRL, 32'h0);

        // Reset mid-count with COUNT=4, then illegal writes.
        step(1, REG_PRESET, 32'd8);
        step(1, REG_CTRL, 32'h9);
        for (int k = 1; k <= 6; k++) step(0, REG_COUNT, 32'd0);
        chk_reg("rc_before", REG_COUNT, 32'd4);
        reset = 1'b0;
        chk_reg("rc_count", REG_COUNT, 32'd0);
        chk_reg("rc_ctrl", REG_CTRL, 32'd0);
        chk_reg("rc_preset", REG_PRESET, 32'd0);
        chk_irq("rc_irq", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step(1, 2'd2, 32'hFFFF);
        chk_reg("wr_count_ignored", REG_COUNT, 32'd0);
        step(1, 2'd3, 32'hFFFF);
        chk_reg("addr3_reads0", 2'd3, 32'd0);
        step(0, REG_COUNT, 32'd0);
        step(0, REG_COUNT, 32'd0);
        chk_reg("post_rst_count", REG_COUNT, 32'd0);
        chk_reg("post_rst_ctrl", REG_CTRL, 32'd0);
        chk_irq("post_rst_irq", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
